// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the memory-access stage (lsu_mem, load_align).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_HL = 4'b0011;
    localparam logic [3:0] BE_HH = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    typedef enum logic {IDLE, WAIT} state_t;

    // Legal width code and naturally aligned address; unknown codes are illegal.
    function automatic logic f3_ok(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return 1'b1;
            F3_H, F3_HU: return ~lo[0];
            F3_W:        return (lo == 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return BE_B0 << lo;
            F3_H, F3_HU: return lo[1] ? BE_HH : BE_HL;
            default:     return BE_W;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B, F3_BU: return {4{d[7:0]}};
            F3_H, F3_HU: return {2{d[15:0]}};
            default:     return d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lo,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_f3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Memory-access stage: execute requests -> req/ack data-memory handshake, load extraction.
// Optional wait timeout with bus error enabled by LSU_TIMEOUT_EN.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] md,
    output logic        md_valid,
    output logic        fault,
    output logic        bus_err
);

    state_t      r_state, w_next;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic        w_access, w_legal, w_accept, w_timeout;
    logic [31:0] w_ld;

    assign w_access = ex_valid & (mem_read | mem_write);
    assign w_legal  = ~(mem_read & mem_write) & f3_ok(funct3, addr[1:0]);
    assign w_accept = (r_state == IDLE) & w_access & w_legal;
    assign stall    = w_accept | ((r_state == WAIT) & ~dm_ack);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    // Fires on the last permitted wait cycle so the bus error lands right after it.
    assign w_timeout = (r_state == WAIT) & ~dm_ack & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state != WAIT) r_cnt <= '0;
        else if (!dm_ack)           r_cnt <= r_cnt + 1'b1;
    end
`else
    logic w_unused_tmo;
    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign bus_err      = 1'b0;
`endif

    load_align u_align (
        .i_rdata (dm_rdata),
        .i_lo    (r_lo),
        .i_f3    (r_f3),
        .o_data  (w_ld)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = WAIT;
            WAIT:    if (dm_ack || w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_f3     <= 3'b000;
            r_lo     <= 2'b00;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= 4'h0;
            dm_addr  <= 32'h0;
            dm_wdata <= 32'h0;
            md       <= 32'h0;
            md_valid <= 1'b0;
            fault    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
        end else begin
            r_state  <= w_next;
            md_valid <= 1'b0;
            fault    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
            if (r_state == IDLE && w_access) begin
                if (w_legal) begin
                    dm_req   <= 1'b1;
                    dm_we    <= mem_write;
                    dm_be    <= be_of(funct3, addr[1:0]);
                    dm_addr  <= {addr[31:2], 2'b00};
                    dm_wdata <= wdata_of(funct3, wdata);
                    r_f3     <= funct3;
                    r_lo     <= addr[1:0];
                end else begin
                    fault <= 1'b1;
                end
            end else if (r_state == WAIT) begin
                if (dm_ack) begin
                    dm_req <= 1'b0;
                    if (!dm_we) begin
                        md       <= w_ld;
                        md_valid <= 1'b1;
                    end
                end else if (w_timeout) begin
                    dm_req <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                    bus_err <= 1'b1;
`endif
                    if (!dm_we) md <= 32'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed self-checking bench for lsu_mem; timeout steps run only with LSU_TIMEOUT_EN.
module tb_lsu_mem;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst, ex_valid, mem_read, mem_write, dm_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, dm_rdata;
    logic        stall, dm_req, dm_we, md_valid, fault, bus_err;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, md;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    lsu_mem #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .md(md), .md_valid(md_valid), .fault(fault),
        .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        ex_valid = 0; mem_read = 0; mem_write = 0; dm_ack = 0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        ex_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = d;
    endtask

    initial begin
        rst = 1; idle_in(); funct3 = 0; addr = 0; wdata = 0; dm_rdata = 0;
        tick(); tick();
        rst = 0; #1;
        chk("rst_req", {31'b0, dm_req}, 0);
        chk("rst_outs", {dm_be, 1'b0, dm_we, md_valid, fault, bus_err, stall}, 0);
        chk("rst_md", md, 0);
        chk("rst_addr", dm_addr | dm_wdata, 0);

        // LB 0x103, ack in first WAIT cycle
        issue(1, 0, 3'b000, 32'h103, 0); #1;
        chk("lb_stall_acc", {31'b0, stall}, 1);
        tick(); idle_in(); dm_ack = 1; dm_rdata = 32'h80112233; #1;
        chk("lb_req", {31'b0, dm_req}, 1);
        chk("lb_addr", dm_addr, 32'h100);
        chk("lb_be", {28'b0, dm_be}, 4'b1000);
        chk("lb_we", {31'b0, dm_we}, 0);
        chk("lb_stall_ack", {31'b0, stall}, 0);
        chk("lb_mdv_early", {31'b0, md_valid}, 0);
        tick(); dm_ack = 0; #1;
        chk("lb_mdv", {31'b0, md_valid}, 1);
        chk("lb_md", md, 32'hFFFFFF80);
        chk("lb_req_off", {31'b0, dm_req}, 0);
        tick(); #1;
        chk("lb_mdv_pulse", {31'b0, md_valid}, 0);

        // LHU 0x202, ack delayed 3 cycles
        issue(1, 0, 3'b101, 32'h202, 0); #1;
        chk("lhu_stall_acc", {31'b0, stall}, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); idle_in(); #1;
            chk("lhu_wait_stall", {31'b0, stall}, 1);
            chk("lhu_wait_req", {31'b0, dm_req}, 1);
            chk("lhu_wait_be", {28'b0, dm_be}, 4'b1100);
            chk("lhu_wait_addr", dm_addr, 32'h200);
        end
        tick(); dm_ack = 1; dm_rdata = 32'hBEEF1234; #1;
        chk("lhu_stall_ack", {31'b0, stall}, 0);
        tick(); dm_ack = 0; #1;
        chk("lhu_md", md, 32'h0000BEEF);
        chk("lhu_mdv", {31'b0, md_valid}, 1);

        // SB 0x301
        tick(); issue(0, 1, 3'b000, 32'h301, 32'h000000A5);
        tick(); idle_in(); dm_ack = 1; #1;
        chk("sb_we", {31'b0, dm_we}, 1);
        chk("sb_be", {28'b0, dm_be}, 4'b0010);
        chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
        tick(); dm_ack = 0; #1;
        chk("sb_mdv", {31'b0, md_valid}, 0);
        chk("sb_md_hold", md, 32'h0000BEEF);

`ifdef LSU_TIMEOUT_EN
        // Load with no ack: bus error after TMO wait cycles
        tick(); issue(1, 0, 3'b010, 32'h500, 0);
        tick(); idle_in();
        for (int i = 0; i < TMO - 1; i++) tick();
        #1;
        chk("tmo_stall_last", {31'b0, stall}, 1);
        chk("tmo_berr_early", {31'b0, bus_err}, 0);
        tick(); #1;
        chk("tmo_berr", {31'b0, bus_err}, 1);
        chk("tmo_req", {31'b0, dm_req}, 0);
        chk("tmo_stall", {31'b0, stall}, 0);
        chk("tmo_md", md, 0);
        chk("tmo_mdv", {31'b0, md_valid}, 0);
`endif

        // Illegal accesses: misaligned LW, funct3=011, read+write
        tick(); issue(1, 0, 3'b010, 32'h402, 0); #1;
        chk("lw_mis_stall", {31'b0, stall}, 0);
        tick(); idle_in(); #1;
        chk("lw_mis_fault", {31'b0, fault}, 1);
        chk("lw_mis_req", {31'b0, dm_req}, 0);
        tick(); #1;
        chk("fault_pulse", {31'b0, fault}, 0);
        issue(1, 0, 3'b011, 32'h0, 0);
        tick(); idle_in(); #1;
        chk("f3_011_fault", {31'b0, fault}, 1);
        chk("f3_011_req", {31'b0, dm_req}, 0);
        issue(1, 1, 3'b010, 32'h0, 0); #1;
        chk("rdwr_stall", {31'b0, stall}, 0);
        tick(); idle_in(); #1;
        chk("rdwr_fault", {31'b0, fault}, 1);

        // Ack in IDLE is ignored
        dm_ack = 1; #1;
        chk("idle_ack_stall", {31'b0, stall}, 0);
        tick(); dm_ack = 0; #1;
        chk("idle_ack_mdv", {31'b0, md_valid}, 0);

        // Reset in WAIT, then a late ack
        issue(1, 0, 3'b000, 32'h103, 0);
        tick(); idle_in(); rst = 1;
        tick(); rst = 0; dm_ack = 1; dm_rdata = 32'h12345678; #1;
        chk("rstw_req", {31'b0, dm_req}, 0);
        chk("rstw_stall", {31'b0, stall}, 0);
        tick(); dm_ack = 0; #1;
        chk("rstw_mdv", {31'b0, md_valid}, 0);
        chk("rstw_md", md, 0);
        chk("rstw_outs", {dm_be, 1'b0, dm_we, dm_req, fault, bus_err, stall}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Memory-access stage of the 5-stage RISC-V core. It sits between execute and the writeback mux.
- Converts execute-stage load/store requests into a req/ack handshake with data memory. It generates byte enables and replicates store data.
- It extracts and sign- or zero-extends load data, and produces the memory-data word consumed by writeback.
- It stalls the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a bus error (only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a valid instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze upstream stages
- dm_req  out  1  memory request, registered
- dm_we  out  1  write enable, registered
- dm_be  out  4  byte enables, registered
- dm_addr  out  32  word address, {addr[31:2],2'b00}, registered
- dm_wdata  out  32  lane-replicated store data, registered
- dm_ack  in  1  memory completes the request this cycle
- dm_rdata  in  32  read word; valid when dm_ack=1
- md  out  32  extended load data to writeback
- md_valid  out  1  one-cycle pulse: md updated
- fault  out  1  one-cycle pulse: misaligned access, illegal funct3, or read and write both set
- bus_err  out  1  one-cycle pulse: timeout (only with LSU_TIMEOUT_EN; otherwise tied 0)

Behaviour:
- Reset values: all outputs 0; state = IDLE.
- FSM states: IDLE, WAIT.
- IDLE, new access: ex_valid & (mem_read|mem_write) is a new access.
  - If legal: register dm_* outputs, set dm_req=1, go to WAIT.
  - If illegal: no request is issued; fault=1 next cycle; stay in IDLE.
- WAIT: dm_req and all dm_* outputs stay stable until dm_ack.
  - On dm_ack: dm_req=0 next cycle, return to IDLE.
  - If the access is a load: md is loaded with the extended data and md_valid=1 on the next cycle.
- stall (combinational) = (IDLE & legal new access) | (WAIT & ~dm_ack). Illegal accesses do not stall.
- Latency: an ack in the first WAIT cycle gives md_valid 2 cycles after acceptance. Each extra memory wait cycle adds 1.
- Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00; B/BU is always aligned. funct3 values 011, 110 and 111 are illegal.
- Store lanes:
  - SB: be=0001<<addr[1:0]; wdata[7:0] replicated to all 4 bytes.
  - SH: be=0011 if addr[1]=0, else 1100; wdata[15:0] replicated.
  - SW: be=1111.
- Loads: dm_we=0, dm_be follows the same lane rules.
- Load extract:
  - byte lane addr[1:0] for B/BU; halfword lane addr[1] for H/HU; W passes the word unchanged.
  - B/H sign-extend; BU/HU zero-extend.
- md holds its value until the next load completes. Stores do not modify md and do not pulse md_valid.
- dm_ack while in IDLE is ignored.
- rst in WAIT: IDLE next edge, dm_req=0. An ack arriving after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8..32-bit counter clears on entry to WAIT and increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES:
  - go to IDLE with dm_req=0;
  - pulse bus_err=1;
  - for a load, set md=32'h0 without pulsing md_valid.
- Undefined: no counter; WAIT is held indefinitely; bus_err is tied 0.

Decomposition:
- lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum (IDLE, WAIT);
  - BE_* lane constants.
- Sub-module load_align: combinational; inputs dm_rdata, addr[1:0], funct3; output is the extended 32-bit word. It is instantiated once in lsu_mem.

Test Plan:
- LB addr=0x103, rdata=0x80112233, ack on first WAIT cycle -> dm_addr=0x100, dm_be=1000, md=0xFFFFFF80, md_valid 2 cycles after accept, stall high 1 cycle.
- LHU addr=0x202, rdata=0xBEEF1234, ack delayed 3 cycles -> dm_be=1100, md=0x0000BEEF, stall high 4 cycles, dm_* stable throughout WAIT.
- SB addr=0x301, wdata=0x000000A5 -> dm_we=1, dm_be=0010, dm_wdata=0xA5A5A5A5; md unchanged; no md_valid.
- LW addr=0x402 -> fault pulse, dm_req never asserted, stall 0. funct3=011 load -> fault. mem_read=mem_write=1 -> fault.
- rst asserted in WAIT, then dm_ack arrives next cycle -> IDLE, dm_req=0, md_valid stays 0, all outputs at reset values.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 WAIT cycles, dm_req=0, stall released, md=0.
